shift_rows_stream: RTL and testbench

SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

---
 rtl/shift_rows_stream.sv | 124 ++++++++++++
 tb/tb_shift_rows_stream.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_stream.sv
// Streaming AES-style ShiftRows: columns in, shifted columns out, via two ping-pong banks.
// Optional inverse mode is enabled by defining SHIFT_ROWS_INV_EN.
module shift_rows_stream #(
  parameter int NB = 4,
  parameter int BW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*BW-1:0] in_col,
  input  logic            in_inv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*BW-1:0] out_col,
  output logic            out_last
);

  localparam int             CW   = $clog2(NB);
  localparam logic [CW-1:0]  LAST = CW'(NB - 1);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0]      r_state [2];
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [CW-1:0]   r_wr_cnt;
  logic [CW-1:0]   r_rd_cnt;
  logic [4*BW-1:0] r_mem [2][NB];

  logic            w_in_fire;
  logic            w_out_fire;
  logic [4*BW-1:0] w_col;

`ifdef SHIFT_ROWS_INV_EN
  logic r_inv [2];
`else
  logic w_unused_inv;
  assign w_unused_inv = in_inv;
`endif

  // The read bank is FULL whenever the write bank is, so in/out transfers never share a bank.
  assign in_ready   = (r_state[r_wr_bank] != ST_FULL);
  assign out_valid  = (r_state[r_rd_bank] == ST_FULL);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state[0] <= ST_EMPTY;
      r_state[1] <= ST_EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
`ifdef SHIFT_ROWS_INV_EN
      r_inv[0]   <= 1'b0;
      r_inv[1]   <= 1'b0;
`endif
    end else begin
      if (w_out_fire) begin
        if (r_rd_cnt == LAST) begin
          r_state[r_rd_bank] <= ST_EMPTY;
          r_rd_bank          <= ~r_rd_bank;
          r_rd_cnt           <= '0;
        end else begin
          r_rd_cnt <= r_rd_cnt + CW'(1);
        end
      end
      if (w_in_fire) begin
        if (r_wr_cnt == LAST) begin
          r_state[r_wr_bank] <= ST_FULL;
          r_wr_bank          <= ~r_wr_bank;
          r_wr_cnt           <= '0;
        end else begin
          r_wr_cnt <= r_wr_cnt + CW'(1);
          if (r_wr_cnt == '0) begin
            r_state[r_wr_bank] <= ST_FILLING;
          end
        end
`ifdef SHIFT_ROWS_INV_EN
        if (r_wr_cnt == '0) begin
          r_inv[r_wr_bank] <= in_inv;
        end
`endif
      end
    end
  end

  // Column storage carries no reset; bank states alone decide what is visible.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_mem[r_wr_bank][r_wr_cnt] <= in_col;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      localparam int OFF = (gi == 0) ? 0 :
                           (gi == 1) ? 1 :
                           (gi == 2) ? ((NB == 8) ? 3 : 2) :
                                       ((NB == 8) ? 4 : 3);
      logic [CW-1:0] w_idx;

      always_comb begin
        w_idx = CW'((int'(r_rd_cnt) + OFF) % NB);
`ifdef SHIFT_ROWS_INV_EN
        if (r_inv[r_rd_bank]) begin
          w_idx = CW'((int'(r_rd_cnt) + NB - OFF) % NB);
        end
`endif
      end

      assign w_col[gi*BW +: BW] = r_mem[r_rd_bank][w_idx][gi*BW +: BW];
    end
  endgenerate

  assign out_col  = out_valid ? w_col : '0;
  assign out_last = out_valid && (r_rd_cnt == LAST);

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed self-checking bench for shift_rows_stream (NB=4 and NB=8 instances).
module tb_shift_rows_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, ir, ii, ov, ordy, ol;
  logic [31:0] ic, oc;
  logic        iv8, ir8, ii8, ov8, or8, ol8;
  logic [31:0] ic8, oc8;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] obs_q[$];

`ifdef SHIFT_ROWS_INV_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  shift_rows_stream #(.NB(4), .BW(8)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir), .in_col(ic), .in_inv(ii),
    .out_valid(ov), .out_ready(ordy), .out_col(oc), .out_last(ol)
  );

  shift_rows_stream #(.NB(8), .BW(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in_col(ic8), .in_inv(ii8),
    .out_valid(ov8), .out_ready(or8), .out_col(oc8), .out_last(ol8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Block 0 reproduces the reference pattern (col c, row r = c*16+r); later blocks are XOR-tagged.
  function automatic logic [7:0] col_byte(input int blk, input int c, input int r);
    return 8'((c * 16 + r) ^ (blk * 4));
  endfunction

  function automatic logic [31:0] col_data(input int blk, input int c);
    logic [31:0] v;
    for (int r = 0; r < 4; r++) v[r*8 +: 8] = col_byte(blk, c, r);
    return v;
  endfunction

  // NB=4 row offsets are 0,1,2,3, i.e. equal to the row number.
  function automatic logic [31:0] exp4(input int blk, input int c, input bit inv);
    logic [31:0] v;
    int src;
    for (int r = 0; r < 4; r++) begin
      src = inv ? (c - r + 4) % 4 : (c + r) % 4;
      v[r*8 +: 8] = col_byte(blk, src, r);
    end
    return v;
  endfunction

  task automatic run4(input string tag, input int nblk, input bit inv, input bit alt,
                      input int stall, output int t4, output int first_ov,
                      output int stalls, output int acc_at_stall, output logic rdy_at_stall);
    int  sent = 0, recv = 0, k = 0, blk, c;
    bit  mode, in_fire, out_fire;
    t4 = -1; first_ov = -1; stalls = 0; acc_at_stall = -1; rdy_at_stall = 1'bx;
    obs_q.delete();
    while (recv < nblk * 4 && k < 400) begin
      blk  = sent / 4;
      c    = sent % 4;
      mode = alt ? bit'(blk % 2) : inv;
      iv   = (sent < nblk * 4);
      ic   = iv ? col_data(blk, c) : '0;
      ii   = (c == 0) ? mode : ~mode;
      ordy = (k >= stall);
      if (k == stall && stall > 0) begin
        acc_at_stall = sent;
        rdy_at_stall = ir;
      end
      if (iv && !ir && ordy) stalls++;
      if (ov) begin
        if (first_ov < 0) first_ov = k;
        mode = alt ? bit'((recv / 4) % 2) : inv;
        check({tag, "_col"}, oc, exp4(recv / 4, recv % 4, mode && INV_ON));
        check({tag, "_last"}, {31'b0, ol}, {31'b0, (recv % 4 == 3)});
      end else begin
        check({tag, "_idle_col"}, oc, 32'h0);
      end
      in_fire  = iv && ir;
      out_fire = ov && ordy;
      if (out_fire) obs_q.push_back(oc);
      cyc();
      k++;
      if (in_fire) begin
        sent++;
        if (sent == 4) t4 = k;
      end
      if (out_fire) recv++;
    end
    check({tag, "_columns_out"}, recv, nblk * 4);
    iv = 1'b0; ic = '0; ii = 1'b0; ordy = 1'b1;
  endtask

  logic [31:0] fwd_exp [4];
  logic [31:0] inv_exp [4];
  int          t4, first_ov, stalls, acc;
  logic        rdy;

  initial begin
    fwd_exp = '{32'h33221100, 32'h03322110, 32'h13023120, 32'h23120130};
    inv_exp = '{32'h13223100, 32'h23320110, 32'h33021120, 32'h03122130};
    rst = 1'b0;
    iv = 0; ic = '0; ii = 0; ordy = 1;
    iv8 = 0; ic8 = '0; ii8 = 0; or8 = 1;

    // Reset state
    repeat (2) cyc();
    check("rst_out_valid", {31'b0, ov}, 32'h0);
    check("rst_out_col", oc, 32'h0);
    check("rst_out_last", {31'b0, ol}, 32'h0);
    check("rst_out_valid8", {31'b0, ov8}, 32'h0);
    rst = 1'b1;
    cyc();
    check("rst_in_ready", {31'b0, ir}, 32'h1);

    // Forward NB=4 reference block, including latency
    run4("fwd", 1, 1'b0, 1'b0, 0, t4, first_ov, stalls, acc, rdy);
    for (int i = 0; i < 4; i++) check($sformatf("fwd_ref%0d", i), obs_q[i], fwd_exp[i]);
    check("fwd_latency", first_ov, t4);

    // Inverse request (ignored unless the inverse feature is built in)
    run4("inv", 1, 1'b1, 1'b0, 0, t4, first_ov, stalls, acc, rdy);
    for (int i = 0; i < 4; i++)
      check($sformatf("inv_ref%0d", i), obs_q[i], INV_ON ? inv_exp[i] : fwd_exp[i]);

    // NB=8 forward
    for (int c = 0; c < 8; c++) begin
      iv8 = 1'b1;
      ic8 = {8'(8*c + 3), 8'(8*c + 2), 8'(8*c + 1), 8'(8*c)};
      check($sformatf("nb8_in_ready%0d", c), {31'b0, ir8}, 32'h1);
      cyc();
    end
    iv8 = 1'b0;
    check("nb8_out_valid", {31'b0, ov8}, 32'h1);
    check("nb8_col0", oc8, 32'h231A0900);
    check("nb8_last0", {31'b0, ol8}, 32'h0);
    repeat (7) cyc();
    check("nb8_col7", oc8, 32'h1B120138);
    check("nb8_last7", {31'b0, ol8}, 32'h1);
    cyc();
    check("nb8_drained", {31'b0, ov8}, 32'h0);

    // Backpressure: three blocks offered with out_ready low for 20 cycles
    run4("bp", 3, 1'b0, 1'b0, 20, t4, first_ov, stalls, acc, rdy);
    check("bp_accepted", acc, 8);
    check("bp_in_ready", {31'b0, rdy}, 32'h0);

    // Streaming: 10 back-to-back blocks, mode alternating per block
    run4("stream", 10, 1'b0, 1'b1, 0, t4, first_ov, stalls, acc, rdy);
    check("stream_bubbles", stalls, 0);
    check("stream_first_ov", first_ov, 4);
    check("stream_t4", t4, 4);

    // Reset after two columns of a block
    iv = 1'b1; ic = col_data(0, 0); cyc();
    ic = col_data(0, 1); cyc();
    iv = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, ov}, 32'h0);
    check("mid_rst_out_col", oc, 32'h0);
    cyc();
    rst = 1'b1;
    cyc();
    check("post_rst_in_ready", {31'b0, ir}, 32'h1);
    check("post_rst_out_valid", {31'b0, ov}, 32'h0);
    run4("post_rst", 1, 1'b0, 1'b0, 0, t4, first_ov, stalls, acc, rdy);
    for (int i = 0; i < 4; i++) check($sformatf("post_rst_ref%0d", i), obs_q[i], fwd_exp[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
